// File: rtl/disposition_sched.sv
// Round-robin scheduler feeding disposition operations from N_REQ requesters
// through an in-order issue FIFO; an empty FIFO presents the all-zero no-op.
module disposition_sched #(
  parameter int N_REQ  = 2,
  parameter int DISP_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DISP_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [DISP_W-1:0]         out_data,
  output logic                      out_nop,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               issue_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(N_REQ);

  logic [DISP_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_level;
  logic [PW-1:0]     r_rr_ptr;
  logic [15:0]       r_issue_cnt;

  logic              w_hi_found;
  logic              w_lo_found;
  logic [PW-1:0]     w_hi_idx;
  logic [PW-1:0]     w_lo_idx;
  logic [PW-1:0]     w_gidx;
  logic              w_full;
  logic              w_pop;
  logic              w_space;
  logic              w_push;
  logic [DISP_W-1:0] w_push_data;

  // Two searches: first valid at or above rr_ptr, and first valid overall for the wrap case.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo_idx   = PW'(i);
      end
      if (req_valid[i] && (i >= 32'(r_rr_ptr)) && !w_hi_found) begin
        w_hi_found = 1'b1;
        w_hi_idx   = PW'(i);
      end
    end
    w_gidx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  assign out_valid = (r_level != '0);
  assign out_data  = out_valid ? r_mem[r_rptr] : '0;
  assign out_nop   = !out_valid;
  assign level     = r_level;
  assign issue_cnt = r_issue_cnt;

  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_pop   = out_valid && out_ready && !flush && !reset;
  assign w_space = !w_full || w_pop;

  always_comb begin
    req_ready = '0;
    if (!reset && !flush && w_lo_found && w_space)
      req_ready[w_gidx] = 1'b1;
  end

  assign w_push = |req_ready;

  always_comb begin
    w_push_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (PW'(i) == w_gidx)
        w_push_data = req_data[i*DISP_W +: DISP_W];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_rr_ptr    <= '0;
      r_issue_cnt <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr   <= r_wptr + 1'b1;
        r_rr_ptr <= (w_gidx == PW'(N_REQ-1)) ? '0 : w_gidx + 1'b1;
      end
      if (w_pop) begin
        r_rptr      <= r_rptr + 1'b1;
        r_issue_cnt <= r_issue_cnt + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_disposition_sched.sv
// Scoreboard bench for disposition_sched: a queue-based reference model predicts
// grants, occupancy and counter; a monitor compares every issued operation.
module tb_disposition_sched;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic           out_ready;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic           out_valid;
  logic           out_nop;
  logic [W-1:0]   out_data;
  logic [LW-1:0]  level;
  logic [15:0]    issue_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb [$];
  int           m_level;
  int           m_rr;
  int unsigned  m_cnt;

  always #5 clk = ~clk;

  disposition_sched #(.N_REQ(N), .DISP_W(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_nop   (out_nop),
    .out_ready (out_ready),
    .level     (level),
    .issue_cnt (issue_cnt)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Lowest valid index at or above rr, otherwise lowest valid index overall.
  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int i = rr; i < N; i++) if (v[i]) return i;
    for (int i = 0; i < rr; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int           g;
    bit           pop;
    bit           push;
    logic [N-1:0] exp_rdy;
    chk("out_valid", W'(out_valid), W'(m_level != 0));
    chk("out_nop", W'(out_nop), W'(m_level == 0));
    chk("level", W'(level), W'(m_level));
    chk("issue_cnt", W'(issue_cnt), W'(m_cnt));
    if (m_level == 0) chk("empty_data", out_data, '0);
    pop = (m_level != 0) && out_ready && !flush && !reset;
    g = pick(req_valid, m_rr);
    exp_rdy = '0;
    if (!reset && !flush && g >= 0 && (m_level < D || pop)) exp_rdy[g] = 1'b1;
    chk("req_ready", W'(req_ready), W'(exp_rdy));
    push = (exp_rdy != '0);
    if (reset) begin
      m_level = 0; m_rr = 0; m_cnt = 0; sb.delete();
    end else if (flush) begin
      m_level = 0; sb.delete();
    end else begin
      if (push) begin
        sb.push_back(req_data[g*W +: W]);
        m_rr = (g + 1) % N;
      end
      if (pop) m_cnt = (m_cnt + 1) % 65536;
      m_level = m_level + int'(push) - int'(pop);
    end
  endtask

  task automatic cyc(input logic [N-1:0] rv, input logic [N*W-1:0] d,
                     input logic ordy, input logic fl, input logic rst);
    @(posedge clk);
    #1;
    req_valid = rv;
    req_data  = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(negedge clk);
    model_step();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=pop required=no_pop");
        end else begin
          chk("out_data", out_data, sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [N-1:0] e;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; req_valid = '0; req_data = '0;
    m_level = 0; m_rr = 0; m_cnt = 0;
    repeat (3) @(posedge clk);

    // reset state and single operation
    cyc(2'b01, {32'h0, 32'h0000_00A5}, 1'b1, 1'b0, 1'b0);
    chk("rst_level", W'(level), '0);
    chk("rst_nop", W'(out_nop), 1);
    chk("single_rdy", W'(req_ready), 2'b01);
    cyc(2'b00, '0, 1'b1, 1'b0, 1'b0);
    chk("single_valid", W'(out_valid), 1);
    chk("single_data", out_data, 32'hA5);
    chk("single_nop", W'(out_nop), 0);
    cyc(2'b00, '0, 1'b1, 1'b0, 1'b0);
    chk("single_nop_after", W'(out_nop), 1);
    chk("single_cnt", W'(issue_cnt), 1);

    // fairness
    cyc('0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(2'b11, {32'hB000_0000 + 32'(k), 32'hA000_0000 + 32'(k)}, 1'b1, 1'b0, 1'b0);
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("fair_grant", W'(req_ready), W'(e));
    end
    cyc('0, '0, 1'b1, 1'b0, 1'b0);

    // full backpressure
    cyc('0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cyc(2'b01, {32'h0, 32'hC000_0000 + 32'(k)}, 1'b0, 1'b0, 1'b0);
    chk("full_level", W'(level), 4);
    chk("full_rdy", W'(req_ready), 0);
    cyc(2'b01, {32'h0, 32'hC000_0010}, 1'b1, 1'b0, 1'b0);
    chk("full_poppush_rdy", W'(req_ready), 2'b01);
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    chk("full_level_hold", W'(level), 4);

    // flush
    cyc('0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(2'b01, {32'h0, 32'hD000_0000 + 32'(k)}, 1'b0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_pre_level", W'(level), 3);
    cyc(2'b10, {32'hD100_0000, 32'h0}, 1'b1, 1'b1, 1'b0);
    chk("flush_rdy", W'(req_ready), 0);
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_level", W'(level), 0);
    chk("flush_nop", W'(out_nop), 1);
    chk("flush_cnt", W'(issue_cnt), 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc(N'($urandom), {$urandom, $urandom}, ($urandom % 10) < 7,
          ($urandom % 40) == 0, ($urandom % 150) == 0);
    end

    // counter wrap, then reset with a partly filled FIFO
    cyc('0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 70000 && m_cnt != 32'hFFFF; i++)
      cyc(2'b01, {32'h0, 32'(i)}, 1'b1, 1'b0, 1'b0);
    if (m_cnt != 32'hFFFF) begin
      checks++;
      errors++;
      $display("FAIL wrap_preload_timeout actual=%0d required=65535", m_cnt);
    end
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    chk("wrap_ffff", W'(issue_cnt), 32'hFFFF);
    cyc('0, '0, 1'b1, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    chk("wrap_zero", W'(issue_cnt), 0);
    cyc(2'b01, {32'h0, 32'hE000_0001}, 1'b0, 1'b0, 1'b0);
    cyc(2'b10, {32'hE000_0002, 32'h0}, 1'b0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_pre_level", W'(level), 2);
    cyc(2'b11, {32'hE100_0000, 32'hE000_0000}, 1'b1, 1'b0, 1'b1);
    chk("rst_rdy", W'(req_ready), 0);
    cyc('0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_level", W'(level), 0);
    chk("rst_valid", W'(out_valid), 0);
    cyc(2'b11, {32'hE100_0001, 32'hE000_0001}, 1'b1, 1'b0, 1'b0);
    chk("rst_rr_grant", W'(req_ready), 2'b01);
    repeat (6) cyc('0, '0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disposition_sched.md
DISPOSITION_SCHED -- requirements
Module: disposition_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter DISP_W, default 32, width of one disposition operation (instantiated as dispositionSize).
REQ-003 SHALL have parameter DEPTH, default 4, issue FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester operation valid.
REQ-007 SHALL have port req_data  input  N_REQ*DISP_W  per-requester operation; requester i occupies bits [i*DISP_W +: DISP_W].
REQ-008 SHALL have port req_ready  output  N_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port flush  input  1  discard all queued operations.
REQ-010 SHALL have port out_valid  output  1  head operation valid toward the disposition unit.
REQ-011 SHALL have port out_data  output  DISP_W  head operation, or the no-op encoding when empty.
REQ-012 SHALL have port out_nop  output  1  high when out_data is the no-op encoding.
REQ-013 SHALL have port out_ready  input  1  disposition unit accepts the head operation.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have port issue_cnt  output  16  count of completed out_valid/out_ready handshakes.

Function
REQ-016 SHALL grant at most one requester per cycle, round-robin from pointer rr_ptr: lowest index >= rr_ptr with req_valid high, else wrap to the lowest valid index.
REQ-017 SHALL advance rr_ptr to (granted index + 1) mod N_REQ only on a completed transfer; rr_ptr SHALL be unchanged otherwise.
REQ-018 SHALL assert a grant only when the FIFO is not full, or is full and a pop completes in the same cycle.
REQ-019 SHALL drive req_ready combinationally from req_valid, rr_ptr, level, out_ready and flush; req_ready[i] SHALL never be high while req_valid[i] is low.
REQ-020 SHALL push the granted req_data into the FIFO tail at the clock edge ending the transfer cycle.
REQ-021 SHALL give latency 1: an operation transferred in cycle t SHALL be presented on out_valid no earlier than cycle t+1, and at t+1 when the FIFO was empty.
REQ-022 SHALL drive out_valid = (level != 0) and out_data = the head entry, preserving transfer order.
REQ-023 SHALL drive out_data = all zeros (the no_opp disposition encoding) and out_nop = 1 when level = 0; out_nop SHALL be 0 otherwise.
REQ-024 SHALL pop the head on out_valid && out_ready; out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-025 SHALL update level by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-026 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-027 SHALL, when flush is high, force req_ready to 0, set level to 0 at that edge, and ignore any pop that cycle; rr_ptr SHALL be unchanged.
REQ-028 SHALL increment issue_cnt on each pop, wrapping 0xFFFF -> 0x0000; flush SHALL NOT clear it.

Reset
REQ-029 SHALL, while reset is high at a clock edge, clear the FIFO pointers, level, rr_ptr and issue_cnt to 0.
REQ-030 SHALL drive req_ready = 0 while reset is high; reset SHALL take priority over flush, push and pop.
REQ-031 SHALL present out_valid = 0, out_nop = 1 and out_data = 0 from the first edge after reset asserts, including when reset asserts mid-operation.

Verification
REQ-032 SHALL check single op: reset, then req_valid[0] = 1 with req_data[0] = 0x0000_00A5 and out_ready = 1 -> req_ready = 01; next cycle out_valid = 1, out_data = 0xA5, out_nop = 0; the following cycle out_nop = 1 and issue_cnt = 1.
REQ-033 SHALL check fairness: both requesters valid continuously, out_ready = 1 -> grants alternate 01, 10, 01, 10 and out_data alternates requester 0 and requester 1 data.
REQ-034 SHALL check full backpressure: out_ready = 0 with 5 offered ops, DEPTH = 4 -> level saturates at 4 and req_ready = 0; raising out_ready for one cycle -> one pop and one push in the same cycle, level stays 4.
REQ-035 SHALL check flush: level = 3, then flush = 1 with req_valid[1] = 1 -> req_ready = 00; next cycle level = 0, out_nop = 1, issue_cnt unchanged.
REQ-036 SHALL check counter wrap and reset: preload via 65535 handshakes -> issue_cnt = 0xFFFF; next handshake -> 0x0000; then reset with level = 2 -> level = 0, out_valid = 0, rr_ptr = 0 (requester 0 granted first afterwards).
